// File: rtl/bit_serializer_pkg.sv
// Shared FSM definitions for the serializer and the sequence-detector blocks.
// Encodings are fixed so every block that decodes state agrees on them.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

endpackage

// File: rtl/bit_serializer_parity_gen.sv
// parity_gen: even parity of a DATA_W-bit word, registered when load is high.
// Only exists when BIT_SERIALIZER_PARITY_EN is defined; the default build has
// no parity logic at all, so the module body is compiled out with it.
`ifdef BIT_SERIALIZER_PARITY_EN
module parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  logic parity_q;
  logic parity_d;

  // Next parity: recompute the XOR reduce on load, otherwise hold.
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = ^data;
    end
  end

  // Parity register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;

endmodule
`endif

// File: rtl/bit_serializer.sv
// bit_serializer: parallel word in (valid/ready), one serial bit per cycle out.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends an even-parity bit
// after each word (DATA_W+1 serial cycles per word instead of DATA_W).
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_last
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic last_data;
  logic final_bit;
  logic handshake;
  logic head_bit;
  logic par_bit;

  assign last_data = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign head_bit  = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];

`ifdef BIT_SERIALIZER_PARITY_EN
  assign final_bit = (state_q == PARITY);

  parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (handshake),
    .data   (in_data),
    .parity (par_bit)
  );
`else
  assign final_bit = last_data;
  assign par_bit   = 1'b0;
`endif

  // Accept a word when idle or while the final serial bit of the current
  // word is on the wire; never while reset is held.
  assign in_ready  = ~rst && ((state_q == IDLE) || final_bit);
  assign handshake = in_valid && in_ready;

  // Next-state, counter and shift-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = in_data;
        end
      end
      SHIFT: begin
        if (!last_data) begin
          cnt_d = cnt_q + 1'b1;
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          end
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = PARITY;
          cnt_d   = '0;
`else
          if (handshake) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = in_data;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (handshake) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = in_data;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and shift-register flops; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Serial outputs decoded from registered state; forced low when idle.
  always_comb begin
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    if (state_q == SHIFT) begin
      out_valid = 1'b1;
      out_bit   = head_bit;
      out_last  = final_bit;
    end else if (state_q == PARITY) begin
      out_valid = 1'b1;
      out_bit   = par_bit;
      out_last  = final_bit;
    end
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the MSB is shifted out first and 0 means the LSB is shifted out first.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk SHALL be an input, 1 bit wide, serving as the single clock; all logic is rising-edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, serving as the synchronous active-high reset.
REQ-006 Port in_data SHALL be an input, DATA_W bits wide, carrying the parallel word to serialize.
REQ-007 Port in_valid SHALL be an input, 1 bit wide, indicating that in_data is valid.
REQ-008 Port in_ready SHALL be an output, 1 bit wide, indicating that the block accepts a word this cycle.
REQ-009 Port out_bit SHALL be an output, 1 bit wide, carrying the serial bit to the downstream sequence detector.
REQ-010 Port out_valid SHALL be an output, 1 bit wide, qualifying out_bit.
REQ-011 Port out_last SHALL be an output, 1 bit wide, high on the final serial bit of each word.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY, with PARITY present only when the macro in REQ-024 is defined.
REQ-013 A handshake SHALL occur on a rising edge when in_valid=1 and in_ready=1; in_data SHALL be captured into the shift register at that edge.
REQ-014 Latency SHALL be exactly one cycle: the first serial bit appears with out_valid=1 in the cycle after the handshake.
REQ-015 The word SHALL be emitted one bit per cycle in SHIFT, DATA_W cycles in total, in the order set by MSB_FIRST; there is no downstream backpressure.
REQ-016 in_ready SHALL be 1 in IDLE and on the final serial bit of a word (the last SHIFT bit, or the PARITY cycle), and 0 otherwise.
REQ-017 If a handshake occurs on the final serial bit, the next word's first bit SHALL follow in the very next cycle with no gap and out_valid remaining 1.
REQ-018 If there is no handshake on the final serial bit, the FSM SHALL go to IDLE with out_valid=0.
REQ-019 Transitions: IDLE->SHIFT on handshake; SHIFT->SHIFT while bit_cnt < DATA_W-1; on the last data bit, SHIFT->PARITY (macro defined) or ->SHIFT (handshake) or ->IDLE; PARITY->SHIFT (handshake) or ->IDLE.
REQ-020 bit_cnt SHALL be $clog2(DATA_W) bits wide, SHALL clear on each load, and SHALL never exceed DATA_W-1.
REQ-021 in_valid while in_ready=0 SHALL be ignored with no state change; upstream holds in_data until accepted.
REQ-022 When out_valid=0, out_bit and out_last SHALL be driven to 0.
REQ-023 out_last SHALL be 1 for exactly one cycle per word, on the last data bit (macro undefined) or the parity bit (macro defined).

Configuration
REQ-024 With macro BIT_SERIALIZER_PARITY_EN defined, each word SHALL be followed by one even-parity bit (XOR of all DATA_W bits of the word), giving DATA_W+1 serial cycles per word.
REQ-025 With BIT_SERIALIZER_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and each word SHALL occupy exactly DATA_W cycles.

Reset
REQ-026 When rst=1 at a rising edge: state SHALL be IDLE, bit_cnt=0, shift register=0, out_bit=0, out_valid=0, out_last=0.
REQ-027 While rst=1 held, in_ready SHALL be 0.
REQ-028 A reset mid-word SHALL discard the word in progress; out_valid SHALL be 0 in the next cycle, and no partial out_last shall be issued.
REQ-029 in_ready SHALL return to 1 in the first cycle after rst deasserts.

Structure
REQ-030 State encodings (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2) SHALL live in the shared FSM package/header used by the sequence-detector blocks.
REQ-031 One sub-module, parity_gen (DATA_W-wide XOR reduce, registered at load), SHALL be instantiated only under BIT_SERIALIZER_PARITY_EN; the shift register and counter SHALL be inline.

Verification
REQ-032 DATA_W=8, MSB_FIRST=1, in_data=8'hDB single word -> out_bit 1,1,0,1,1,0,1,1 in cycles 1..8 after handshake; out_last in cycle 8; out_valid=0 in cycle 9.
REQ-033 Back-to-back 8'hDB then 8'h6C with in_valid held high -> 16 contiguous valid bits 11011011 01101100; in_ready high only in cycles 0, 8 and 16.
REQ-034 MSB_FIRST=0, in_data=8'h1B -> bits 1,1,0,1,1,0,0,0; downstream 11011 detector fires once.
REQ-035 rst asserted in cycle 4 of 8'hFF -> out_valid=0 from cycle 5, no out_last, in_ready=1 after rst deasserts; next word 8'h00 serializes cleanly.
REQ-036 BIT_SERIALIZER_PARITY_EN defined: 8'hDB -> 8 data bits then parity bit 0 (six ones), out_last on cycle 9; 8'hDA -> parity bit 1.
REQ-037 in_valid toggled while busy (cycles 2..6) with changing in_data -> no capture; output stream is the original word only.
